// File: rtl/frontend_stream_tx.sv
// Buffered stream transmitter: a word buffer loaded while idle is replayed
// NUM_FRAMES times as FRAME_LEN-word frames. Optional tlast_out via TX_TLAST_EN.
module frontend_stream_tx #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 7,
  parameter int FRAME_LEN  = 64,
  parameter int NUM_FRAMES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              tvalid_out,
  input  logic              tready_out,
  output logic [DATA_W-1:0] tdata_out,
  output logic              busy,
  output logic              done
`ifdef TX_TLAST_EN
  ,
  output logic              tlast_out
`endif
);

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0]  LAST_WORD  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   word_idx, word_next;
  logic [FRAME_W-1:0]  frame_idx, frame_next;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                wr_accept;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign wr_accept = en && wr_en && (state == IDLE);

  // NOTE: the buffer array has no reset so it maps onto block RAM; reset
  // leaves its contents untouched.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: every output and next-state signal is defaulted first so that no
  // path through the case statement can infer a latch.
  always_comb begin
    state_next = state;
    word_next  = word_idx;
    frame_next = frame_idx;
    rd_en      = 1'b0;
    rd_addr    = word_idx;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          word_next  = '0;
          frame_next = '0;
        end
      end

      FETCH: begin
        rd_en      = 1'b1;
        rd_addr    = word_idx;
        state_next = SEND;
      end

      SEND: begin
        // A transfer reads the following word in the same edge, so the
        // next word is presented without a bubble.
        if (tready_out) begin
          if (word_idx == LAST_WORD) begin
            word_next = '0;
            if (frame_idx == LAST_FRAME) begin
              state_next = DONE;
            end else begin
              frame_next = frame_idx + FRAME_W'(1);
              rd_en      = 1'b1;
              rd_addr    = '0;
            end
          end else begin
            word_next = word_idx + ADDR_W'(1);
            rd_en     = 1'b1;
            rd_addr   = word_idx + ADDR_W'(1);
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_idx  <= '0;
      frame_idx <= '0;
      tdata_out <= '0;
    end else if (en) begin
      state     <= state_next;
      word_idx  <= word_next;
      frame_idx <= frame_next;
      if (rd_en) begin
        tdata_out <= mem[rd_addr];
      end
    end
  end

  // Outputs decode the held state, so en=0 freezes them along with it.
  assign tvalid_out = (state == SEND);
  assign busy       = (state == FETCH) || (state == SEND);
  assign done       = (state == DONE);

`ifdef TX_TLAST_EN
  assign tlast_out  = (state == SEND) && (word_idx == LAST_WORD);
`endif

endmodule

// File: tb/tb_frontend_stream_tx.sv
// Self-checking bench for frontend_stream_tx: a transaction-level model of the
// buffer and expected word stream, random handshakes, and a startup vector table.
module tb_frontend_stream_tx;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int FL = 64;
  localparam int NF = 10;
  localparam int TOTAL = FL * NF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          tready_out = 1'b0;
  logic          tvalid_out;
  logic [DW-1:0] tdata_out;
  logic          busy;
  logic          done;
`ifdef TX_TLAST_EN
  logic          tlast_out;
`endif

  frontend_stream_tx #(
    .DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL), .NUM_FRAMES(NF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .tvalid_out(tvalid_out),
    .tready_out(tready_out), .tdata_out(tdata_out), .busy(busy), .done(done)
`ifdef TX_TLAST_EN
    , .tlast_out(tlast_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct packed {
    logic          v;
    logic          b;
    logic          d;
    logic [DW-1:0] data;
  } samp_t;

  typedef struct {
    logic          en, st, we, rdy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    exp_vbd;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] model_mem [1 << AW];
  word_t         exp_q[$];
  logic          model_idle = 1'b1;
  logic          done_due = 1'b0;
  logic          pending = 1'b0;
  logic          last_xfer = 1'b0;
  logic          prev_en = 1'b1;
  logic          prev_done_s = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW+2:0] prev_outs = '0;
  int            n_xfer = 0;
  int            done_pulses = 0;
  int            cyc = 0;
  int            first_cyc = -1;
  int            last_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: sample outputs at the falling edge, check them,
  // apply inputs, and advance the model for the coming rising edge.
  task automatic step(input logic en_v, input logic rdy_v, input logic st_v,
                      input logic we_v, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output samp_t s);
    logic  xfer;
    logic  new_done;
    word_t e;
    @(negedge clk);
    cyc++;
    new_done = 1'b0;
    s = {tvalid_out, busy, done, tdata_out};

    if (!prev_en) check("en_low_freeze", 64'({tvalid_out, busy, done, tdata_out}), 64'(prev_outs));
    if (pending) begin
      check("stall_valid", 64'(tvalid_out), 64'(1));
      check("stall_data", 64'(tdata_out), 64'(prev_data));
    end
    if (last_xfer && exp_q.size() > 0) check("no_bubble", 64'(tvalid_out), 64'(1));
    if (done_due) check("done_pulse", 64'({done, busy, tvalid_out}), 64'(3'b100));
    else if (model_idle) check("idle_outputs", 64'({done, busy, tvalid_out}), 64'(3'b000));
    else check("busy_high", 64'({done, busy}), 64'(2'b01));
    if (done && !prev_done_s) done_pulses++;

    en = en_v; tready_out = rdy_v; start = st_v; wr_en = we_v; wr_addr = a; wr_data = d;

    xfer = tvalid_out && rdy_v && en_v;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("spurious_xfer", 64'(tvalid_out), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", 64'(tdata_out), 64'(e.data));
`ifdef TX_TLAST_EN
        check("xfer_tlast", 64'(tlast_out), 64'(e.last));
`endif
        n_xfer++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) new_done = 1'b1;
      end
    end

    if (done_due) begin
      if (en_v) begin
        done_due   = 1'b0;
        model_idle = 1'b1;
      end
    end else if (model_idle && en_v) begin
      if (we_v) model_mem[a] = d;
      if (st_v) begin
        model_idle = 1'b0;
        for (int f = 0; f < NF; f++)
          for (int w = 0; w < FL; w++)
            exp_q.push_back('{data: model_mem[w], last: (w == FL - 1)});
      end
    end
    if (new_done) done_due = 1'b1;

    pending     = tvalid_out && !(rdy_v && en_v);
    last_xfer   = xfer;
    prev_en     = en_v;
    prev_done_s = done;
    prev_data   = tdata_out;
    prev_outs   = {tvalid_out, busy, done, tdata_out};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; start = 1'b0; wr_en = 1'b0; tready_out = 1'b1;
    @(negedge clk);
    check("reset_ctrl", 64'({tvalid_out, busy, done}), 64'(3'b000));
    check("reset_tdata", 64'(tdata_out), 64'(0));
`ifdef TX_TLAST_EN
    check("reset_tlast", 64'(tlast_out), 64'(0));
`endif
    rst = 1'b0; en = 1'b1; tready_out = 1'b0;
    exp_q.delete();
    model_idle = 1'b1; done_due = 1'b0; pending = 1'b0; last_xfer = 1'b0;
    prev_en = 1'b1; prev_done_s = 1'b0;
  endtask

  task automatic start_run();
    samp_t s;
    done_pulses = 0; first_cyc = -1; last_cyc = -1;
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, s);
  endtask

  // mode 0: ready and enable held high; mode 1: random ready and enable.
  task automatic run_to_done(input int mode);
    samp_t s;
    int    guard = 0;
    logic  r, e;
    while (!model_idle && guard < 4000) begin
      r = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      e = (mode == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
      step(e, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, (1 << AW) - 1)), $urandom, s);
      guard++;
    end
    check("run_complete", 64'(model_idle), 64'(1));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    samp_t s;
    int    base_x;
    int    guard;
    vec_t  tbl[7];

    tbl[0] = '{en:1, st:1, we:1, rdy:0, a:0, d:32'hDEAD, exp_vbd:3'b000, chk_data:0, exp_data:0};
    tbl[1] = '{en:1, st:1, we:1, rdy:0, a:0, d:32'hBEEF, exp_vbd:3'b010, chk_data:0, exp_data:0};
    tbl[2] = '{en:0, st:0, we:0, rdy:1, a:0, d:0,        exp_vbd:3'b110, chk_data:1, exp_data:32'hDEAD};
    tbl[3] = '{en:1, st:0, we:1, rdy:1, a:1, d:32'h1234, exp_vbd:3'b110, chk_data:1, exp_data:32'hDEAD};
    tbl[4] = '{en:1, st:0, we:0, rdy:1, a:0, d:0,        exp_vbd:3'b110, chk_data:1, exp_data:2};
    tbl[5] = '{en:1, st:0, we:0, rdy:0, a:0, d:0,        exp_vbd:3'b110, chk_data:1, exp_data:3};
    tbl[6] = '{en:1, st:0, we:0, rdy:1, a:0, d:0,        exp_vbd:3'b110, chk_data:1, exp_data:3};

    for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
    do_reset();

    // Load data = addr + 1, plus a write with en low that must be dropped.
    for (int a = 0; a < FL; a++) step(1'b1, 1'b0, 1'b0, 1'b1, AW'(a), DW'(a + 1), s);
    step(1'b0, 1'b0, 1'b0, 1'b1, AW'(5), 32'hFFFF, s);

    // Continuous ready: back-to-back transfers and one done pulse.
    base_x = n_xfer;
    start_run();
    run_to_done(0);
    check("xfer_total_cont", 64'(n_xfer - base_x), 64'(TOTAL));
    check("consecutive", 64'(last_cyc - first_cyc + 1), 64'(TOTAL));
    check("done_pulses_cont", 64'(done_pulses), 64'(1));

    // Random ready and enable with writes/starts while busy.
    base_x = n_xfer;
    start_run();
    run_to_done(1);
    check("xfer_total_rand", 64'(n_xfer - base_x), 64'(TOTAL));
    check("done_pulses_rand", 64'(done_pulses), 64'(1));

    // Reset after 100 transfers aborts without done, then a clean restart.
    base_x = n_xfer;
    start_run();
    guard = 0;
    while (n_xfer - base_x < 100 && guard < 400) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, s);
      guard++;
    end
    check("xfers_before_reset", 64'(n_xfer - base_x), 64'(100));
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, s);
    check("no_done_after_abort", 64'(done_pulses), 64'(0));
    base_x = n_xfer;
    start_run();
    run_to_done(1);
    check("xfer_total_restart", 64'(n_xfer - base_x), 64'(TOTAL));

    // Start and write together in IDLE; start/write while busy ignored.
    base_x = n_xfer;
    done_pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].en, tbl[i].rdy, tbl[i].st, tbl[i].we, tbl[i].a, tbl[i].d, s);
      check($sformatf("vec%0d_vbd", i), 64'({s.v, s.b, s.d}), 64'(tbl[i].exp_vbd));
      if (tbl[i].chk_data) check($sformatf("vec%0d_data", i), 64'(s.data), 64'(tbl[i].exp_data));
    end
    run_to_done(0);
    check("xfer_total_table", 64'(n_xfer - base_x), 64'(TOTAL));

    // en held low for 5 cycles mid-frame with ready high.
    base_x = n_xfer;
    start_run();
    guard = 0;
    while (n_xfer - base_x < 30 && guard < 200) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, s);
      guard++;
    end
    guard = n_xfer;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, s);
    check("en_low_no_xfer", 64'(n_xfer - guard), 64'(0));
    run_to_done(0);
    check("xfer_total_en", 64'(n_xfer - base_x), 64'(TOTAL));

    // Buffer still holds DEAD at 0 and 2 at 1 despite busy-time writes.
    base_x = n_xfer;
    start_run();
    run_to_done(1);
    check("xfer_total_final", 64'(n_xfer - base_x), 64'(TOTAL));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
